// File: rtl/perf_counter_sampler.sv
// Sweeps performance-counter slots 1..NUM_COUNTERS on a start pulse or periodic tick,
// captures each slot's read data (optionally clearing it) and streams it out valid/ready.
module perf_counter_sampler #(
  parameter int NUM_COUNTERS = 12,
  parameter int PERIOD       = 1024,
  parameter int MISSED_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    auto_en,
  input  logic                    clear_on_read,
  output logic [15:0]             counter_address,
  output logic                    counter_clear,
  input  logic [15:0]             counter_rdata,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic [15:0]             sample_data,
  output logic [3:0]              sample_index,
  output logic                    sample_last,
  output logic                    busy,
  output logic                    done,
  output logic [MISSED_WIDTH-1:0] missed_count
);

  // state  | meaning
  // S_IDLE | waiting for start or tick
  // S_READ | one cycle: drive slot address/clear, capture read data
  // S_OUT  | sample word presented until accepted
  typedef enum logic [1:0] {S_IDLE, S_READ, S_OUT} state_t;

  localparam int              TW        = $clog2(PERIOD);
  localparam logic [TW-1:0]   TIMER_MAX = TW'(PERIOD - 1);
  localparam logic [3:0]      LAST_IDX  = 4'(NUM_COUNTERS);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [TW-1:0]           r_timer;
  logic [3:0]              r_idx;
  logic                    r_clr_mode;
  logic [15:0]             r_sample_data;
  logic [3:0]              r_sample_index;
  logic                    r_sample_last;
  logic                    r_done;
  logic [MISSED_WIDTH-1:0] r_missed;

  logic                    w_tick;
  logic                    w_trigger;
  logic                    w_busy;
  logic                    w_accept;
  logic [15:0]             w_slot_addr;

  assign w_tick      = auto_en & (r_timer == TIMER_MAX);
  assign w_trigger   = start | w_tick;
  assign w_busy      = (r_state != S_IDLE);
  assign w_accept    = (r_state == S_OUT) & sample_ready;
  // Slots occupy descending 16-bit words from the top of the address space.
  assign w_slot_addr = 16'hFFFE - {11'd0, r_idx - 4'd1, 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_trigger) w_state_nxt = S_READ;
      S_READ: w_state_nxt = S_OUT;
      S_OUT:  if (w_accept) w_state_nxt = r_sample_last ? S_IDLE : S_READ;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timer        <= '0;
      r_idx          <= '0;
      r_clr_mode     <= 1'b0;
      r_sample_data  <= '0;
      r_sample_index <= '0;
      r_sample_last  <= 1'b0;
      r_done         <= 1'b0;
      r_missed       <= '0;
    end else begin
      if (!auto_en || r_timer == TIMER_MAX) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end

      r_done <= w_accept & r_sample_last;

      if (w_trigger && w_busy && !(&r_missed)) begin
        r_missed <= r_missed + MISSED_WIDTH'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_idx      <= 4'd1;
            r_clr_mode <= clear_on_read;
          end
        end
        S_READ: begin
          r_sample_data  <= counter_rdata;
          r_sample_index <= r_idx;
          r_sample_last  <= (r_idx == LAST_IDX);
        end
        S_OUT: begin
          if (w_accept && !r_sample_last) begin
            r_idx <= r_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign counter_address = (r_state == S_READ) ? w_slot_addr : 16'h0000;
  assign counter_clear   = (r_state == S_READ) & r_clr_mode;
  assign sample_valid    = (r_state == S_OUT);
  assign sample_data     = r_sample_data;
  assign sample_index    = r_sample_index;
  assign sample_last     = r_sample_last;
  assign busy            = w_busy;
  assign done            = r_done;
  assign missed_count    = r_missed;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Self-checking bench for perf_counter_sampler: cycle vector table plus directed
// sequences for full sweeps, clear-on-read, back-pressure, reset and auto ticks.
module tb_perf_counter_sampler;

  localparam int NUM = 12;
  localparam int PER = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        auto_en;
  logic        clear_on_read;
  logic [15:0] counter_address;
  logic        counter_clear;
  logic [15:0] counter_rdata;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_data;
  logic [3:0]  sample_index;
  logic        sample_last;
  logic        busy;
  logic        done;
  logic [7:0]  missed_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  perf_counter_sampler #(.NUM_COUNTERS(NUM), .PERIOD(PER), .MISSED_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_en(auto_en),
    .clear_on_read(clear_on_read), .counter_address(counter_address),
    .counter_clear(counter_clear), .counter_rdata(counter_rdata),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_data(sample_data), .sample_index(sample_index),
    .sample_last(sample_last), .busy(busy), .done(done),
    .missed_count(missed_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter bank model: slot s at address FFFE-2*(s-1), cleared at the edge.
  logic [15:0] bank [1:15];
  logic        bank_init;
  int          rd_slot;

  function automatic int slot_of(input logic [15:0] a);
    return (int'(16'hFFFE) - int'(a)) / 2 + 1;
  endfunction

  always_comb begin
    rd_slot       = slot_of(counter_address);
    counter_rdata = 16'hDEAD;
    if (rd_slot >= 1 && rd_slot <= 15) counter_rdata = bank[rd_slot];
  end

  always @(posedge clk) begin
    if (bank_init) begin
      for (int i = 1; i <= 15; i++) bank[i] <= 16'h1000 + 16'(i);
    end else if (counter_clear && rd_slot >= 1 && rd_slot <= 15) begin
      bank[rd_slot] <= 16'h0000;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},   32'(counter_address), 32'h0);
    chk({tag, "_clear"},  32'(counter_clear),   32'h0);
    chk({tag, "_valid"},  32'(sample_valid),    32'h0);
    chk({tag, "_data"},   32'(sample_data),     32'h0);
    chk({tag, "_index"},  32'(sample_index),    32'h0);
    chk({tag, "_last"},   32'(sample_last),     32'h0);
    chk({tag, "_busy"},   32'(busy),            32'h0);
    chk({tag, "_done"},   32'(done),            32'h0);
    chk({tag, "_missed"}, 32'(missed_count),    32'h0);
  endtask

  // One full start-triggered sweep, checked every cycle; optional stall on one slot.
  task automatic do_sweep(input logic cor, input logic zeros, input int stall_idx,
                          input int stall_len, input string tag);
    int slot = 1;
    int n = 0;
    int stalled = 0;
    int busy_cyc = 0;
    int clr_cyc = 0;
    bit fin = 0;
    bit accepted = 0;
    bit was_last = 0;
    logic [15:0] exp_data;
    start = 1'b1; clear_on_read = cor; sample_ready = 1'b1;
    tick_clk();
    start = 1'b0; clear_on_read = ~cor;
    while (!fin && n < 400) begin
      n++;
      if (accepted) begin
        accepted = 0;
        if (was_last) begin
          chk({tag, "_done_pulse"}, 32'(done), 32'h1);
          chk({tag, "_busy_end"},   32'(busy), 32'h0);
          fin = 1;
        end else begin
          slot++;
        end
      end
      if (!fin) begin
        if (busy) busy_cyc++;
        if (counter_clear) clr_cyc++;
        chk({tag, "_done_low"}, 32'(done), 32'h0);
        if (busy && !sample_valid) begin
          chk({tag, "_read_addr"},  32'(counter_address), 32'hFFFE - 32'(2 * (slot - 1)));
          chk({tag, "_read_clear"}, 32'(counter_clear),   32'(cor));
        end else if (sample_valid) begin
          exp_data = zeros ? 16'h0000 : 16'h1000 + 16'(slot);
          chk({tag, "_index"},     32'(sample_index),    32'(slot));
          chk({tag, "_data"},      32'(sample_data),     32'(exp_data));
          chk({tag, "_last"},      32'(sample_last),     32'(slot == NUM));
          chk({tag, "_out_addr"},  32'(counter_address), 32'h0);
          chk({tag, "_out_clear"}, 32'(counter_clear),   32'h0);
          if (slot == stall_idx && stalled < stall_len) begin
            sample_ready = 1'b0;
            stalled++;
          end else begin
            sample_ready = 1'b1;
            accepted = 1;
            was_last = (slot == NUM);
          end
        end else begin
          chk({tag, "_busy_mid"}, 32'(busy), 32'h1);
        end
        tick_clk();
      end
    end
    chk({tag, "_finished"},   32'(fin),      32'h1);
    chk({tag, "_busy_count"}, 32'(busy_cyc), 32'(2 * NUM + stall_len));
    chk({tag, "_clr_count"},  32'(clr_cyc),  cor ? 32'(NUM) : 32'h0);
    tick_clk();
    chk({tag, "_done_once"}, 32'(done), 32'h0);
  endtask

  task automatic next_rise(output int at, input int limit, input string tag);
    int n = 0;
    logic prev;
    at = -1;
    prev = busy;
    while (n < limit && at < 0) begin
      tick_clk();
      n++;
      if (!prev && busy) at = cyc;
      prev = busy;
    end
    chk({tag, "_rise_seen"}, 32'(at >= 0), 32'h1);
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        busy;
    logic        valid;
    logic        clear;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  idx;
    logic [7:0]  missed;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int   t0, t1, t2, t3, t4;
    int   n;
    bit   found;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h0000, 4'd0, 8'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1001, 4'd1, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1001, 4'd1, 8'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFC, 16'h1001, 4'd1, 8'd0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1002, 4'd2, 8'd0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFA, 16'h1002, 4'd2, 8'd0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h1003, 4'd3, 8'd1};

    rst_n = 1'b0; start = 1'b0; auto_en = 1'b0; clear_on_read = 1'b0;
    sample_ready = 1'b0; bank_init = 1'b1;
    tick_clk();
    tick_clk();
    chk_all_zero("reset");
    bank_init = 1'b0; rst_n = 1'b1;
    tick_clk();

    for (int i = 0; i < 7; i++) begin
      start = vecs[i].start; sample_ready = vecs[i].ready;
      tick_clk();
      chk($sformatf("vec%0d_busy", i),   32'(busy),            32'(vecs[i].busy));
      chk($sformatf("vec%0d_valid", i),  32'(sample_valid),    32'(vecs[i].valid));
      chk($sformatf("vec%0d_clear", i),  32'(counter_clear),   32'(vecs[i].clear));
      chk($sformatf("vec%0d_addr", i),   32'(counter_address), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_data", i),   32'(sample_data),     32'(vecs[i].data));
      chk($sformatf("vec%0d_index", i),  32'(sample_index),    32'(vecs[i].idx));
      chk($sformatf("vec%0d_missed", i), 32'(missed_count),    32'(vecs[i].missed));
    end
    start = 1'b0;

    rst_n = 1'b0; sample_ready = 1'b0;
    tick_clk();
    chk_all_zero("rst_after_table");
    rst_n = 1'b1;
    tick_clk();

    do_sweep(1'b0, 1'b0, 0, 0, "sweep_plain");
    do_sweep(1'b1, 1'b0, 0, 0, "sweep_clear");
    do_sweep(1'b0, 1'b1, 0, 0, "sweep_zeros");

    bank_init = 1'b1;
    tick_clk();
    bank_init = 1'b0;
    do_sweep(1'b0, 1'b0, 3, 5, "sweep_stall");

    start = 1'b1; sample_ready = 1'b1; clear_on_read = 1'b0;
    tick_clk();
    start = 1'b0;
    found = 0; n = 0;
    while (!found && n < 60) begin
      n++;
      if (sample_valid && sample_index == 4'd5) found = 1;
      else tick_clk();
    end
    chk("midreset_reach_idx5", 32'(found), 32'h1);
    rst_n = 1'b0; sample_ready = 1'b0;
    tick_clk();
    chk_all_zero("midreset");
    rst_n = 1'b1;
    tick_clk();
    chk("midreset_idle_addr", 32'(counter_address), 32'h0);
    do_sweep(1'b0, 1'b0, 0, 0, "sweep_after_reset");

    auto_en = 1'b1; sample_ready = 1'b1;
    next_rise(t0, 100, "auto0");
    next_rise(t1, 100, "auto1");
    chk("auto_period1", 32'(t1 - t0), 32'(PER));
    next_rise(t2, 100, "auto2");
    chk("auto_period2", 32'(t2 - t1), 32'(PER));
    chk("auto_missed", 32'(missed_count), 32'h0);

    n = 0;
    while (cyc < t2 + PER - 1 && n < 100) begin
      tick_clk();
      n++;
    end
    chk("coincide_idle", 32'(busy), 32'h0);
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    chk("coincide_busy", 32'(busy), 32'h1);
    chk("coincide_addr", 32'(counter_address), 32'hFFFE);
    chk("coincide_missed", 32'(missed_count), 32'h0);
    repeat (3) tick_clk();
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    chk("busy_start_missed", 32'(missed_count), 32'h1);
    next_rise(t3, 100, "auto3");
    chk("auto_period3", 32'(t3 - (t2 + PER)), 32'(PER));

    next_rise(t4, 100, "auto4");
    sample_ready = 1'b0;
    repeat (100) tick_clk();
    chk("stuck_busy", 32'(busy), 32'h1);
    chk("stuck_missed", 32'(missed_count), 32'h4);

    start = 1'b1;
    repeat (300) tick_clk();
    start = 1'b0;
    chk("saturate_missed", 32'(missed_count), 32'hFF);

    auto_en = 1'b0; sample_ready = 1'b1;
    n = 0;
    while (busy && n < 60) begin
      tick_clk();
      n++;
    end
    chk("drain_idle", 32'(busy), 32'h0);
    chk("saturate_hold", 32'(missed_count), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
